// File: rtl/node_pixel_writer_pkg.sv
// Shared definitions for the node pixel writer: amplitude format, colour bands, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package node_pixel_writer_pkg;

    // Node amplitudes are signed 5.27 fixed point.
    localparam int FP_W = 32;

    // Band thresholds, k << 27 for k = 6, 4, 2, 0, -2, -4, -6.
    localparam logic signed [FP_W-1:0] FP_POS6 = 32'sh3000_0000;
    localparam logic signed [FP_W-1:0] FP_POS4 = 32'sh2000_0000;
    localparam logic signed [FP_W-1:0] FP_POS2 = 32'sh1000_0000;
    localparam logic signed [FP_W-1:0] FP_ZERO = 32'sh0000_0000;
    localparam logic signed [FP_W-1:0] FP_NEG2 = 32'shF000_0000;
    localparam logic signed [FP_W-1:0] FP_NEG4 = 32'shE000_0000;
    localparam logic signed [FP_W-1:0] FP_NEG6 = 32'shD000_0000;

    // RGB332 colour for each band, highest band first.
    localparam logic [7:0] RGB_POS6  = 8'hE0;
    localparam logic [7:0] RGB_POS4  = 8'hE8;
    localparam logic [7:0] RGB_POS2  = 8'hCD;
    localparam logic [7:0] RGB_ZERO  = 8'h00;
    localparam logic [7:0] RGB_NEG2  = 8'h77;
    localparam logic [7:0] RGB_NEG4  = 8'hF8;
    localparam logic [7:0] RGB_NEG6  = 8'hE3;
    localparam logic [7:0] RGB_FLOOR = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_WR,
        S_STEP,
        S_WAIT
    } state_t;

endpackage

// File: rtl/amplitude_colour_map.sv
// Maps a signed 5.27 node amplitude to an RGB332 colour; exact thresholds fall in the higher band.
// Latency: combinational.
// Backpressure: none.
// Ports: amplitude (signed 5.27 in), colour (RGB332 out).
module amplitude_colour_map
    import node_pixel_writer_pkg::*;
(
    input  logic signed [FP_W-1:0] amplitude,
    output logic [7:0]             colour
);

    always_comb begin
        colour = RGB_FLOOR;
        if (amplitude >= FP_POS6)      colour = RGB_POS6;
        else if (amplitude >= FP_POS4) colour = RGB_POS4;
        else if (amplitude >= FP_POS2) colour = RGB_POS2;
        else if (amplitude >= FP_ZERO) colour = RGB_ZERO;
        else if (amplitude >= FP_NEG2) colour = RGB_NEG2;
        else if (amplitude >= FP_NEG4) colour = RGB_NEG4;
        else if (amplitude >= FP_NEG6) colour = RGB_NEG6;
    end

endmodule

// File: rtl/node_pixel_writer.sv
// Reads grid node amplitudes, writes one RGB332 pixel row per time step, then starts the next step.
// Latency: 3 cycles per node minimum (REQ, CAP, WR); row ends with a step_start pulse and a step_done wait.
// Backpressure: pix_write/addr/data held until pix_ready; grid is only restarted after step_done.
// Ports: clk, reset (sync, active-low), enable; node_sel/node_data grid read port;
//        pix_write/pix_addr/pix_data/pix_ready pixel-buffer port; step_start/step_done grid control;
//        row_index and frame_wrap report the row being drawn and the bottom-of-screen wrap.
module node_pixel_writer
    import node_pixel_writer_pkg::*;
#(
    parameter int NUM_NODES  = 64,
    parameter int SEL_W      = 6,
    parameter int FRAME_ROWS = 480,
    parameter int ROW_STRIDE = 640,
    parameter int X_OFFSET   = 0,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [SEL_W-1:0]  node_sel,
    input  logic [FP_W-1:0]   node_data,
    output logic              pix_write,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_data,
    input  logic              pix_ready,
    output logic              step_start,
    input  logic              step_done,
    output logic [9:0]        row_index,
    output logic              frame_wrap
);

    localparam logic [SEL_W-1:0] LAST_NODE = SEL_W'(NUM_NODES - 1);
    localparam logic [9:0]       LAST_ROW  = 10'(FRAME_ROWS - 1);
    localparam logic [9:0]       STRIDE    = 10'(ROW_STRIDE);
    localparam int               SUM_W     = 21;

    state_t            state, state_n;
    logic [SEL_W-1:0]  node_cnt, node_cnt_n;
    logic              pix_write_n;
    logic [ADDR_W-1:0] pix_addr_n;
    logic [7:0]        pix_data_n;
    logic              step_start_n;
    logic [9:0]        row_index_n;
    logic              frame_wrap_n;
    // Cleared on entry to WAIT so step_done is ignored for the first WAIT cycle.
    logic              wait_armed, wait_armed_n;
    logic [7:0]        colour;
    logic [19:0]       row_base;
    logic [ADDR_W-1:0] node_addr;

    amplitude_colour_map u_colour_map (
        .amplitude (node_data),
        .colour    (colour)
    );

    // The counter is presented directly; it only changes on entry to REQ,
    // so node_data for it is valid by the CAP cycle.
    assign node_sel = node_cnt;

    // 10x10 multiply zero-extended to 20 bits, so the product cannot overflow.
    assign row_base  = {10'd0, row_index} * {10'd0, STRIDE};
    assign node_addr = ADDR_W'({1'b0, row_base} + SUM_W'(X_OFFSET) + SUM_W'(node_cnt));

    always_comb begin
        state_n      = state;
        node_cnt_n   = node_cnt;
        pix_write_n  = pix_write;
        pix_addr_n   = pix_addr;
        pix_data_n   = pix_data;
        step_start_n = 1'b0;
        row_index_n  = row_index;
        frame_wrap_n = 1'b0;
        wait_armed_n = wait_armed;

        case (state)
            S_IDLE: begin
                if (enable) begin
                    node_cnt_n = '0;
                    state_n    = S_REQ;
                end
            end
            S_REQ: begin
                state_n = S_CAP;
            end
            S_CAP: begin
                pix_data_n  = colour;
                pix_addr_n  = node_addr;
                pix_write_n = 1'b1;
                state_n     = S_WR;
            end
            S_WR: begin
                if (pix_ready) begin
                    pix_write_n = 1'b0;
                    if (node_cnt == LAST_NODE) begin
                        step_start_n = 1'b1;
                        state_n      = S_STEP;
                    end else begin
                        node_cnt_n = node_cnt + 1'b1;
                        state_n    = S_REQ;
                    end
                end
            end
            S_STEP: begin
                wait_armed_n = 1'b0;
                state_n      = S_WAIT;
            end
            S_WAIT: begin
                if (!wait_armed) begin
                    wait_armed_n = 1'b1;
                end else if (step_done) begin
                    if (row_index == LAST_ROW) begin
                        row_index_n  = '0;
                        frame_wrap_n = 1'b1;
                    end else begin
                        row_index_n = row_index + 1'b1;
                    end
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            node_cnt   <= '0;
            pix_write  <= 1'b0;
            pix_addr   <= '0;
            pix_data   <= '0;
            step_start <= 1'b0;
            row_index  <= '0;
            frame_wrap <= 1'b0;
            wait_armed <= 1'b0;
        end else begin
            state      <= state_n;
            node_cnt   <= node_cnt_n;
            pix_write  <= pix_write_n;
            pix_addr   <= pix_addr_n;
            pix_data   <= pix_data_n;
            step_start <= step_start_n;
            row_index  <= row_index_n;
            frame_wrap <= frame_wrap_n;
            wait_armed <= wait_armed_n;
        end
    end

endmodule

// File: tb/tb_node_pixel_writer.sv
// Scoreboard bench for node_pixel_writer: random node amplitudes and pixel-buffer backpressure,
// expected writes queued per row from a band-lookup model, a negedge monitor pops and compares.
// A 16-node row keeps a full 480-row frame (plus wrap) short.
module tb_node_pixel_writer;

    localparam int NN     = 16;
    localparam int SW     = 4;
    localparam int ROWS   = 480;
    localparam int STRIDE = 640;
    localparam int AW     = 19;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [SW-1:0] node_sel;
    logic [31:0]   node_data;
    logic          pix_write;
    logic [AW-1:0] pix_addr;
    logic [7:0]    pix_data;
    logic          pix_ready;
    logic          step_start;
    logic          step_done;
    logic [9:0]    row_index;
    logic          frame_wrap;

    node_pixel_writer #(
        .NUM_NODES  (NN),
        .SEL_W      (SW),
        .FRAME_ROWS (ROWS),
        .ROW_STRIDE (STRIDE),
        .X_OFFSET   (0),
        .ADDR_W     (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .node_sel   (node_sel),
        .node_data  (node_data),
        .pix_write  (pix_write),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .step_start (step_start),
        .step_done  (step_done),
        .row_index  (row_index),
        .frame_wrap (frame_wrap)
    );

    typedef struct {
        int         addr;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] row_vals[NN];
    int          checks;
    int          errors;
    int          model_row;
    int          rows_done;
    int          writes;
    int          steps;
    int          wraps;
    int          stall_seen;
    int          cyc;
    bit          mon_en;
    bit          force_low;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Band lookup on the real-valued amplitude.
    function automatic logic [7:0] ref_colour(input logic [31:0] v);
        int  iv;
        real a;
        iv = $signed(v);
        a  = iv / 134217728.0;
        if (a >= 6.0)       return 8'hE0;
        else if (a >= 4.0)  return 8'hE8;
        else if (a >= 2.0)  return 8'hCD;
        else if (a >= 0.0)  return 8'h00;
        else if (a >= -2.0) return 8'h77;
        else if (a >= -4.0) return 8'hF8;
        else if (a >= -6.0) return 8'hE3;
        else                return 8'hFF;
    endfunction

    // New amplitudes for the row about to be drawn, and the writes it must produce.
    task automatic gen_row();
        logic [31:0] sweep[8];
        sweep = '{32'h3000_0000, 32'h2FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF,
                  32'hD000_0000, 32'h8000_0000, 32'hF000_0000, 32'h7FFF_FFFF};
        for (int n = 0; n < NN; n++) begin
            int k;
            k = int'($urandom_range(0, 15)) - 8;
            if (rows_done == 0) begin
                row_vals[n] = 32'h3000_0000;
            end else if (rows_done == 1) begin
                row_vals[n] = sweep[n % 8];
            end else begin
                case ($urandom_range(0, 3))
                    0:       row_vals[n] = 32'(k * 134217728);
                    1:       row_vals[n] = 32'(k * 134217728 - 1);
                    default: row_vals[n] = $urandom();
                endcase
            end
            exp_q.push_back('{addr: (model_row * STRIDE + n) % (1 << AW),
                              data: ref_colour(row_vals[n])});
        end
    endtask

    task automatic wait_rows(input int n, input int budget);
        int c;
        c = 0;
        while (rows_done < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rows_reached", 64'(rows_done >= n), 64'd1);
    endtask

    // Grid read port: amplitude of the node selected one cycle earlier.
    initial begin
        logic [SW-1:0] sel_prev;
        sel_prev  = '0;
        node_data = '0;
        forever begin
            @(posedge clk); #1;
            node_data = row_vals[sel_prev];
            sel_prev  = node_sel;
        end
    end

    // Pixel-buffer backpressure: none in row 0, a 5-cycle stall on node 10 in row 1, random after.
    initial begin
        int stalled;
        stalled   = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (force_low) begin
                pix_ready = 1'b0;
            end else if (rows_done == 0) begin
                pix_ready = 1'b1;
            end else if (rows_done == 1) begin
                if (pix_write && pix_addr == AW'(STRIDE + 10) && stalled < 5) begin
                    pix_ready = 1'b0;
                    stalled++;
                end else begin
                    pix_ready = 1'b1;
                end
            end else begin
                pix_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Grid step model: spurious step_done in STEP and first WAIT cycle, real pulse 4 cycles later.
    initial begin
        bit wrapped;
        step_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (step_start === 1'b1 && reset === 1'b1) begin
                step_done = 1'b1;
                @(posedge clk); #1;
                step_done = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    step_done = 1'b0;
                end
                chk("row_hold", 64'(row_index), 64'(model_row));
                @(posedge clk); #1;
                step_done = 1'b1;
                @(posedge clk); #1;
                step_done = 1'b0;
                wrapped   = (model_row == ROWS - 1);
                model_row = wrapped ? 0 : model_row + 1;
                chk("row_step", 64'(row_index), 64'(model_row));
                chk("frame_wrap", 64'(frame_wrap), 64'(wrapped));
                rows_done++;
                if (enable) gen_row();
            end
        end
    end

    // Monitor: scoreboard pops on accepted writes, plus stall stability and step timing.
    initial begin
        exp_t          e;
        bit            prev_pend;
        logic [AW-1:0] prev_addr;
        logic [7:0]    prev_data;
        logic [SW-1:0] prev_sel;
        int            last_acc;
        prev_pend = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        prev_sel  = '0;
        last_acc  = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_en) begin
                prev_pend = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("stall_write", 64'(pix_write), 64'd1);
                    chk("stall_addr", 64'(pix_addr), 64'(prev_addr));
                    chk("stall_data", 64'(pix_data), 64'(prev_data));
                    chk("stall_sel", 64'(node_sel), 64'(prev_sel));
                end
                if (rows_done == 1 && pix_write && !pix_ready && pix_addr == AW'(STRIDE + 10))
                    stall_seen++;
                prev_pend = pix_write && !pix_ready;
                prev_addr = pix_addr;
                prev_data = pix_data;
                prev_sel  = node_sel;
                if (pix_write && pix_ready) begin
                    writes++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                                 pix_addr, pix_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_addr", 64'(pix_addr), 64'(e.addr));
                        chk("pix_data", 64'(pix_data), 64'(e.data));
                    end
                    if (writes > 1 && writes <= NN)
                        chk("node_gap", 64'(cyc - last_acc), 64'd3);
                    last_acc = cyc;
                end
                if (step_start) begin
                    steps++;
                    chk("step_after_last", 64'(cyc - last_acc), 64'd1);
                end
                if (frame_wrap) wraps++;
            end
        end
    end

    initial begin
        int c;
        int w0;
        int s0;
        checks     = 0;
        errors     = 0;
        model_row  = 0;
        rows_done  = 0;
        writes     = 0;
        steps      = 0;
        wraps      = 0;
        stall_seen = 0;
        cyc        = 0;
        mon_en     = 1'b0;
        force_low  = 1'b0;
        reset      = 1'b0;
        enable     = 1'b0;
        for (int n = 0; n < NN; n++) row_vals[n] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_node_sel", 64'(node_sel), 64'd0);
        chk("rst_pix_write", 64'(pix_write), 64'd0);
        chk("rst_pix_addr", 64'(pix_addr), 64'd0);
        chk("rst_pix_data", 64'(pix_data), 64'd0);
        chk("rst_step_start", 64'(step_start), 64'd0);
        chk("rst_row_index", 64'(row_index), 64'd0);
        chk("rst_frame_wrap", 64'(frame_wrap), 64'd0);

        gen_row();
        mon_en = 1'b1;
        reset  = 1'b1;
        enable = 1'b1;

        wait_rows(2, 2000);
        chk("stall_cycles", 64'(stall_seen), 64'd5);

        wait_rows(ROWS + 1, 60000);

        // Reset while a write is stalled in WR.
        force_low = 1'b1;
        c = 0;
        while (pix_write !== 1'b1 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("wr_before_reset", 64'(pix_write), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_pix_write", 64'(pix_write), 64'd0);
        chk("mid_rst_row_index", 64'(row_index), 64'd0);
        chk("mid_rst_node_sel", 64'(node_sel), 64'd0);
        chk("mid_rst_pix_addr", 64'(pix_addr), 64'd0);
        chk("mid_rst_step_start", 64'(step_start), 64'd0);

        exp_q.delete();
        model_row = 0;
        gen_row();
        force_low = 1'b0;
        reset     = 1'b1;
        mon_en    = 1'b1;

        // Drop enable mid-row: the row must finish, then nothing more is drawn.
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        wait_rows(ROWS + 2, 2000);
        w0 = writes;
        s0 = steps;
        repeat (30) @(posedge clk);
        #1;
        chk("idle_no_writes", 64'(writes - w0), 64'd0);
        chk("idle_no_step", 64'(steps - s0), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("total_steps", 64'(steps), 64'(ROWS + 2));
        chk("total_wraps", 64'(wraps), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
